data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
Arbitrates the single-port data RAM between the CPU MEM stage and the UART debug/loader host. Each access is sequenced through a small FSM that handles the RAM's fixed read latency. The pipeline is stalled until the CPU's access completes. The UART side uses a req/ack handshake. The block sits between the MEM-stage control signals (mem_read/mem_write) and the data RAM.

Parameters:
ADDR_W, 10, word-address width of the data RAM
DATA_W, 32, data width
RD_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata (legal range 1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cpu_mem_read  in  1  MEM-stage load request
cpu_mem_write  in  1  MEM-stage store request
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU load data (registered)
cpu_stall  out  1  freeze pipeline (combinational)
uart_req  in  1  UART access request, held until uart_ack
uart_we  in  1  UART write enable (1 = write)
uart_addr  in  ADDR_W  UART word address
uart_wdata  in  DATA_W  UART write data
uart_rdata  out  DATA_W  UART read data (registered)
uart_ack  out  1  one-cycle completion pulse
mem_en  out  1  RAM access strobe (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- cpu_req = cpu_mem_read | cpu_mem_write. If both are high, the access is treated as a write.
- FSM states: IDLE, ISSUE, WAIT, DONE. An owner register holds CPU or UART. A last_grant bit records the previous owner.
- IDLE:
  - One requester pending: grant it.
  - Both pending: grant the one that is not last_grant (round-robin).
  - On grant: latch address, data and write flag into mem_* regs, then go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle, mem_we=write flag.
  - Write: go to DONE.
  - Read: load the latency counter with RD_LAT, then go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, capture mem_rdata into cpu_rdata or uart_rdata (per owner), then go to DONE.
- DONE: release the access, update last_grant to owner, and return to IDLE.
  - UART owner: uart_ack=1 for this cycle.
  - Requests in the DONE cycle are ignored (no re-grant of the same request).
- mem_en/mem_we are 0 in every state except ISSUE. mem_addr/mem_wdata hold their last values.
- cpu_stall = rst_n & cpu_req & ~(state==DONE & owner==CPU).
  - The stall covers the cycles where the request waits in IDLE or ISSUE/WAIT, and also UART-owned cycles.
- Latency from the grant cycle T:
  - Write: mem_en at T+1, DONE at T+2.
  - Read: mem_en at T+1, data captured at T+1+RD_LAT, DONE at T+2+RD_LAT.
- cpu_rdata/uart_rdata change only on capture and are stable from DONE until the next capture.
- UART: uart_req must remain high until uart_ack. Dropping uart_req while the access is in flight does not abort it; ack is still issued.
- Reset (rst_n=0 at any edge): state=IDLE, owner=CPU, last_grant=UART (CPU wins the first contention), counter=0.
  - mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, uart_rdata and uart_ack are all 0.
  - An in-flight access is abandoned with no ack and no data capture.
  - cpu_stall=0 while rst_n=0.
- No starvation: with both sides requesting continuously, grants strictly alternate.

Test Plan:
- CPU load, RD_LAT=1: addr 0x005, RAM[5]=0xDEADBEEF, no UART traffic -> cpu_stall high for 3 cycles (T..T+2), mem_en pulses at T+1 with we=0, cpu_rdata=0xDEADBEEF with stall low at T+3.
- CPU store: addr 0x00A, data 0x12345678 -> mem_en=mem_we=1 at T+1 with mem_addr=0x00A and mem_wdata=0x12345678, stall low at T+2, a following load from 0x00A returns 0x12345678.
- UART read, RD_LAT=3: uart_req with addr 0x010, RAM[0x10]=0xA5A5A5A5 -> uart_ack single pulse at T+5, uart_rdata=0xA5A5A5A5, cpu_stall stays 0 with no CPU request.
- Simultaneous CPU load and UART write from reset -> CPU granted first, UART write issued immediately after CPU DONE, cpu_stall low only in CPU DONE, uart_ack once.
- Continuous contention for 8 accesses -> grant order C,U,C,U,C,U,C,U, and mem_en never asserted in two consecutive cycles.
- rst_n driven low during WAIT of a UART read -> next cycle all outputs 0 and state IDLE, no uart_ack, uart_rdata remains 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage and the UART debug/loader host.
// Each access runs IDLE -> ISSUE -> (WAIT) -> DONE. Round-robin is used when both sides contend.
`timescale 1ns/1ps
module data_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              uart_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_UART = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              is_write_q, is_write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] uart_rdata_q, uart_rdata_d;

  logic cpu_req;
  logic grant_cpu;
  logic grant_uart;

  assign cpu_req = cpu_mem_read | cpu_mem_write;

  // On contention the side that did not win last time gets the RAM.
  assign grant_cpu  = cpu_req & (~uart_req | (last_grant_q == OWN_UART));
  assign grant_uart = uart_req & ~grant_cpu;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    uart_rdata_d = uart_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_cpu || grant_uart) begin
          owner_d     = grant_uart ? OWN_UART : OWN_CPU;
          is_write_d  = grant_uart ? uart_we : cpu_mem_write;
          mem_addr_d  = grant_uart ? uart_addr : cpu_addr;
          mem_wdata_d = grant_uart ? uart_wdata : cpu_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = is_write_d;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (is_write_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (owner_q == OWN_UART) begin
            uart_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_UART;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      uart_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      uart_rdata_q <= uart_rdata_d;
    end
  end

  // The CPU is released only in the DONE cycle of its own access.
  assign cpu_stall  = rst_n & cpu_req & ~((state_q == S_DONE) & (owner_q == OWN_CPU));
  assign uart_ack   = (state_q == S_DONE) & (owner_q == OWN_UART);
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign uart_rdata = uart_rdata_q;

endmodule
